// File: rtl/fetch_npc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_npc_unit_if
// Description : Bundle of the fetch-stage signals: hazard stall, D-stage
//               next-PC controls, instruction-memory bus and F/D outputs.
//               master = fetch unit side, slave = pipeline/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_npc_unit_if;
  // Hazard unit
  logic        i_stall;
  // D-stage next-PC controls
  logic [1:0]  i_npc_sel;
  logic        i_br_taken_d;
  logic [31:0] i_imm32_d;
  logic [25:0] i_instr_index_d;
  logic [31:0] i_rs_data_d;
  // Instruction memory
  logic [31:0] o_im_addr;
  logic [31:0] i_im_rdata;
  // F/D pipeline register
  logic [31:0] o_instr_d;
  logic [31:0] o_pc_d;
  logic [31:0] o_pc8_d;
  logic        o_valid_d;
  logic        o_fetch_fault_d;

  modport master (
    input  i_stall, i_npc_sel, i_br_taken_d, i_imm32_d, i_instr_index_d,
           i_rs_data_d, i_im_rdata,
    output o_im_addr, o_instr_d, o_pc_d, o_pc8_d, o_valid_d, o_fetch_fault_d
  );

  modport slave (
    output i_stall, i_npc_sel, i_br_taken_d, i_imm32_d, i_instr_index_d,
           i_rs_data_d, i_im_rdata,
    input  o_im_addr, o_instr_d, o_pc_d, o_pc8_d, o_valid_d, o_fetch_fault_d
  );
endinterface : fetch_npc_unit_if
`default_nettype wire

// File: rtl/fetch_npc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_npc_unit
// Description : MIPS fetch stage with next-PC selection. Holds PC_F, drives
//               the instruction-memory address, checks fetch legality and
//               registers the fetched word into the F/D register.
//               Optional macro IFU_DELAY_SLOT_EN: when defined, the
//               instruction in F on a redirect is kept as the delay slot;
//               when undefined, that slot is flushed to an invalid nop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
  input  wire logic          clk,
  input  wire logic          reset,   // synchronous, active-low
  fetch_npc_unit_if.master   bus
);

  localparam logic [1:0]  c_SEL_SEQ    = 2'b00;
  localparam logic [1:0]  c_SEL_BRANCH = 2'b01;
  localparam logic [1:0]  c_SEL_JUMP   = 2'b10;
  localparam logic [1:0]  c_SEL_REG    = 2'b11;
  localparam logic [31:0] c_NOP        = 32'h0000_0000;

  // Architectural state: PC in F and the F/D pipeline register
  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic        r_fault_d;

  // Next-PC datapath
  logic [31:0] w_pc_d_plus4;
  logic [31:0] w_pc_f_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_target;
  logic        w_redirect;
  logic [31:0] w_npc;

  // Fetch legality and F/D load values
  logic        w_fault_f;
  logic [31:0] w_fd_instr;
  logic [31:0] w_fd_pc;
  logic        w_fd_valid;
  logic        w_fd_fault;

  // Targets are all derived from the instruction sitting in D (pc_d)
  assign w_pc_d_plus4 = r_pc_d + 32'd4;
  assign w_pc_f_plus4 = r_pc_f + 32'd4;
  assign w_br_target  = w_pc_d_plus4 + (bus.i_imm32_d << 2);
  assign w_j_target   = {w_pc_d_plus4[31:28], bus.i_instr_index_d, 2'b00};

  // Select redirect target and decide whether a redirect happens
  always_comb begin
    w_target   = w_pc_f_plus4;
    w_redirect = 1'b0;
    case (bus.i_npc_sel)
      c_SEL_BRANCH: begin
        w_target   = w_br_target;
        w_redirect = bus.i_br_taken_d;
      end
      c_SEL_JUMP: begin
        w_target   = w_j_target;
        w_redirect = 1'b1;
      end
      c_SEL_REG: begin
        w_target   = bus.i_rs_data_d;
        w_redirect = 1'b1;
      end
      c_SEL_SEQ: begin
        w_target   = w_pc_f_plus4;
        w_redirect = 1'b0;
      end
      default: begin
        w_target   = w_pc_f_plus4;
        w_redirect = 1'b0;
      end
    endcase
  end

  assign w_npc = w_redirect ? w_target : w_pc_f_plus4;

  // A fetch is illegal if misaligned or outside the instruction window
  assign w_fault_f = (r_pc_f[1:0] != 2'b00) || (r_pc_f < IM_LO) || (r_pc_f > IM_HI);

  // Build the F/D load values; a faulted fetch becomes a valid, flagged nop
  always_comb begin
    w_fd_instr = w_fault_f ? c_NOP : bus.i_im_rdata;
    w_fd_pc    = r_pc_f;
    w_fd_valid = 1'b1;
    w_fd_fault = w_fault_f;
`ifdef IFU_DELAY_SLOT_EN
    // Delay slot: the instruction in F is kept even when redirecting
`else
    // No delay slot: the wrong-path instruction in F is squashed
    if (w_redirect) begin
      w_fd_instr = c_NOP;
      w_fd_valid = 1'b0;
      w_fd_fault = 1'b0;
    end
`endif
  end

  // PC and F/D update: reset > stall > redirect/sequential
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc_f    <= RESET_PC;
      r_instr_d <= c_NOP;
      r_pc_d    <= RESET_PC;
      r_valid_d <= 1'b0;
      r_fault_d <= 1'b0;
    end else if (!bus.i_stall) begin
      r_pc_f    <= w_npc;
      r_instr_d <= w_fd_instr;
      r_pc_d    <= w_fd_pc;
      r_valid_d <= w_fd_valid;
      r_fault_d <= w_fd_fault;
    end
  end

  assign bus.o_im_addr       = r_pc_f;
  assign bus.o_instr_d       = r_instr_d;
  assign bus.o_pc_d          = r_pc_d;
  assign bus.o_pc8_d         = r_pc_d + 32'd8;
  assign bus.o_valid_d       = r_valid_d;
  assign bus.o_fetch_fault_d = r_fault_d;

endmodule : fetch_npc_unit
`default_nettype wire

// File: doc/fetch_npc_unit.md
# fetch_npc_unit

Fetch stage plus next-PC logic for the five-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and registers the fetched word into the F/D pipeline register. It consumes the D-stage sign/zero-extended immediate (32-bit result of the D-stage immediate extender) together with the D-stage branch decision to compute redirect targets. Stall input comes from the hazard unit.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- IM_LO, 32'h0000_3000, lowest legal fetch address
- IM_HI, 32'h0000_6ffc, highest legal fetch address
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  synchronous, active-low; sampled on rising clk
- stall  in  1  hazard unit freezes PC and F/D register
- npc_sel  in  2  00 PC+4, 01 branch, 10 jump (j/jal), 11 register (jr/jalr)
- br_taken_d  in  1  branch condition true, used only when npc_sel=01
- imm32_d  in  32  extended immediate of the instruction in D
- instr_index_d  in  26  instr_d[25:0] for jump target
- rs_data_d  in  32  forwarded rs value for register jump
- im_addr  out  32  instruction-memory byte address (= PC_F)
- im_rdata  in  32  combinational instruction-memory read data
- instr_d  out  32  F/D instruction
- pc_d  out  32  F/D PC
- pc8_d  out  32  pc_d + 8, link value
- valid_d  out  1  F/D holds a real instruction
- fetch_fault_d  out  1  F/D instruction fetched from misaligned or out-of-range address

## Operation
- PC_F register; im_addr = PC_F.
- redirect = (npc_sel==01 & br_taken_d) | npc_sel==10 | npc_sel==11.
- Targets, all 32-bit modulo 2^32:
  - branch: pc_d + 4 + (imm32_d << 2)
  - jump: {pc_d_plus4[31:28], instr_index_d, 2'b00}, where pc_d_plus4 = pc_d + 4
  - register: rs_data_d, used unmodified
- Next PC: redirect ? target : PC_F + 4.
- Fault: PC_F[1:0]!=0, PC_F<IM_LO or PC_F>IM_HI. On fault the F/D register loads instr_d=0 (nop), fetch_fault_d=1, valid_d=1. The fault flag travels with pc_d, and the PC still advances normally.
- Update priority on each rising edge: reset low > stall > redirect > sequential.
  - Reset: PC_F=RESET_PC, instr_d=0, pc_d=RESET_PC, valid_d=0, fetch_fault_d=0.
  - Stall: PC_F and all F/D outputs hold; a redirect presented during stall is ignored and must be re-presented by D, which is held, next cycle.
  - Otherwise PC_F <= next PC and F/D <= {im_rdata or nop, PC_F, fault, 1}.
- pc8_d is purely combinational from pc_d.
- There are no internal states beyond the PC and F/D registers; the first post-reset cycle fetches RESET_PC.

## Timing
- Fetch latency: address presented in cycle n, instruction visible on instr_d after edge n+1.
- Redirect: D-stage inputs are sampled at edge n, and PC_F = target after that edge. The target instruction reaches instr_d after edge n+1.
- Stall asserted for k cycles holds the outputs for exactly k edges. Deassertion resumes with the held values, with no loss or duplication.
- Reset deasserted at edge n: the first valid_d=1 appears after edge n+1.
- Reset asserted mid-stream overrides stall and redirect in the same edge.

## Configuration
- IFU_DELAY_SLOT_EN defined: MIPS delay slot. On redirect, the instruction currently in F (PC_F) is loaded into F/D normally, and valid_d=1.
- IFU_DELAY_SLOT_EN undefined: on redirect, F/D is flushed with instr_d=0, valid_d=0, fetch_fault_d=0, and pc_d=PC_F. Target calculation is identical in both modes.

## Test plan
- Reset low 2 cycles, then high. Required: im_addr 0x3000 → 0x3004 → 0x3008; instr_d follows im_rdata one edge later; valid_d=0 until the first edge after reset release.
- pc_d=0x3010, npc_sel=01, br_taken_d=1, imm32_d=0xFFFF_FFFC. Required: PC_F=0x3004 next cycle. With npc_sel=01 and br_taken_d=0: PC_F=PC_F+4.
- pc_d=0x3020, npc_sel=10, instr_index_d=0x0000C40. Required: PC_F=0x0000_3100. pc8_d=0x3028.
- stall=1 for 3 cycles with npc_sel=11 and rs_data_d=0x3400 present. Required: all outputs frozen for 3 edges; redirect to 0x3400 only on the first unstalled edge.
- npc_sel=11, rs_data_d=0x3002. Required: next F/D holds fetch_fault_d=1, instr_d=0. With rs_data_d=0x7000: also fault.
- Redirect with IFU_DELAY_SLOT_EN defined: F/D gets the PC_F+0 instruction with valid_d=1. Undefined: instr_d=0, valid_d=0.
